// File: rtl/sc_backg_shiftcounter.sv
// Background pattern shift register and modulo timing counter driven by the background control FSM.
// Optional macro SC_BACKGSHIFTCOUNTER_ROTATE_EN turns the zero-fill shifts into rotates.
module sc_backg_shiftcounter #(
    parameter int unsigned               DATA_WIDTH     = 8,
    parameter int unsigned               COUNT_WIDTH    = 8,
    parameter int unsigned               TERMINAL_COUNT = 200,
    parameter logic [DATA_WIDTH-1:0]     INIT_PATTERN   = DATA_WIDTH'(1)
) (
    input  logic                   SC_BACKGSHIFTCOUNTER_CLOCK_50,
    input  logic                   SC_BACKGSHIFTCOUNTER_RESET_InLow,
    input  logic                   SC_BACKGSHIFTCOUNTER_clear_InLow,
    input  logic                   SC_BACKGSHIFTCOUNTER_load_InLow,
    input  logic [1:0]             SC_BACKGSHIFTCOUNTER_shiftselection_In,
    input  logic                   SC_BACKGSHIFTCOUNTER_upcount_InLow,
    input  logic [DATA_WIDTH-1:0]  SC_BACKGSHIFTCOUNTER_data_InBUS,
    output logic [DATA_WIDTH-1:0]  SC_BACKGSHIFTCOUNTER_data_OutBUS,
    output logic [COUNT_WIDTH-1:0] SC_BACKGSHIFTCOUNTER_count_OutBUS,
    output logic                   SC_BACKGSHIFTCOUNTER_T0_OutLow
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TERMINAL_COUNT - 1);

    // Encoding chosen so the state bit itself is the active-low T0 output.
    typedef enum logic {
        StTerm = 1'b0,
        StIdle = 1'b1
    } t0_state_e;

    logic [DATA_WIDTH-1:0]  data_reg;
    logic [DATA_WIDTH-1:0]  shl_val;
    logic [DATA_WIDTH-1:0]  shr_val;
    logic [COUNT_WIDTH-1:0] count_reg;
    t0_state_e              t0_state;

    always_comb begin
`ifdef SC_BACKGSHIFTCOUNTER_ROTATE_EN
        shl_val = {data_reg[DATA_WIDTH-2:0], data_reg[DATA_WIDTH-1]};
        shr_val = {data_reg[0], data_reg[DATA_WIDTH-1:1]};
`else
        shl_val = {data_reg[DATA_WIDTH-2:0], 1'b0};
        shr_val = {1'b0, data_reg[DATA_WIDTH-1:1]};
`endif
    end

    always_ff @(posedge SC_BACKGSHIFTCOUNTER_CLOCK_50) begin
        if (!SC_BACKGSHIFTCOUNTER_RESET_InLow) begin
            data_reg <= INIT_PATTERN;
        end else if (!SC_BACKGSHIFTCOUNTER_clear_InLow) begin
            data_reg <= INIT_PATTERN;
        end else if (!SC_BACKGSHIFTCOUNTER_load_InLow) begin
            data_reg <= SC_BACKGSHIFTCOUNTER_data_InBUS;
        end else begin
            case (SC_BACKGSHIFTCOUNTER_shiftselection_In)
                2'b10:   data_reg <= shl_val;
                2'b01:   data_reg <= shr_val;
                default: data_reg <= data_reg;
            endcase
        end
    end

    // Counter and T0 flag machine; T0 stays low until the next increment or clear.
    always_ff @(posedge SC_BACKGSHIFTCOUNTER_CLOCK_50) begin
        if (!SC_BACKGSHIFTCOUNTER_RESET_InLow) begin
            count_reg <= '0;
            t0_state  <= StIdle;
        end else if (!SC_BACKGSHIFTCOUNTER_clear_InLow) begin
            count_reg <= '0;
            t0_state  <= StIdle;
        end else if (!SC_BACKGSHIFTCOUNTER_upcount_InLow) begin
            if (count_reg == LAST_COUNT) begin
                count_reg <= '0;
                t0_state  <= StTerm;
            end else begin
                count_reg <= count_reg + COUNT_WIDTH'(1);
                t0_state  <= StIdle;
            end
        end
    end

    assign SC_BACKGSHIFTCOUNTER_data_OutBUS  = data_reg;
    assign SC_BACKGSHIFTCOUNTER_count_OutBUS = count_reg;
    assign SC_BACKGSHIFTCOUNTER_T0_OutLow    = t0_state;

endmodule
